// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) with flush and result-bus stall.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow complete after a single cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IN_valid,
  input  logic [XLEN-1:0] IN_srcA,
  input  logic [XLEN-1:0] IN_srcB,
  input  logic [1:0]      IN_opcode,
  input  logic [6:0]      IN_tagDst,
  input  logic [4:0]      IN_nmDst,
  input  logic [6:0]      IN_sqN,
  input  logic            IN_branchTaken,
  input  logic [6:0]      IN_branchSqN,
  input  logic            IN_wbStall,
  output logic            OUT_busy,
  output logic            OUT_resValid,
  output logic [XLEN-1:0] OUT_result,
  output logic [6:0]      OUT_tagDst,
  output logic [4:0]      OUT_nmDst,
  output logic [6:0]      OUT_sqN
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_p0, quo_p0, dvs_p0, srca_p0;
  logic            is_rem_p0, sgn_q_p0, sgn_r_p0, bz_p0, ovf_p0;
  logic [6:0]      tag_p0, sqn_p0;
  logic [4:0]      nm_p0;

  // Younger-than-branch test on 7-bit wrapping sequence numbers.
  function automatic logic killed(input logic [6:0] sqn, input logic [6:0] bsqn, input logic taken);
    logic [6:0] d;
    d = sqn - bsqn;
    return taken && !d[6] && (d != 7'd0);
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic s);
    return s ? (~v + XLEN'(1)) : v;
  endfunction

  logic            is_signed, in_bz, in_ovf, kill_held;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff, rem_nx, quo_nx, q_fin, r_fin, res_fin;
  logic            ge;

  assign is_signed = ~IN_opcode[0];
  assign in_bz     = (IN_srcB == '0);
  assign in_ovf    = is_signed && (IN_srcA == MIN_NEG) && (IN_srcB == '1);
  assign kill_held = killed(sqn_p0, IN_branchSqN, IN_branchTaken);

  always_comb begin
    rem_sh  = {rem_p0, quo_p0[XLEN-1]};
    ge      = (rem_sh >= {1'b0, dvs_p0});
    diff    = rem_sh[XLEN-1:0] - dvs_p0;
    rem_nx  = ge ? diff : rem_sh[XLEN-1:0];
    quo_nx  = {quo_p0[XLEN-2:0], ge};
    q_fin   = neg_if(quo_nx, sgn_q_p0);
    r_fin   = neg_if(rem_nx, sgn_r_p0);
    // Architected results for x/0 and MIN/-1 override whatever the iteration produced.
    if (bz_p0) begin
      q_fin = '1;
      r_fin = srca_p0;
    end else if (ovf_p0) begin
      q_fin = MIN_NEG;
      r_fin = '0;
    end
    res_fin = is_rem_p0 ? r_fin : q_fin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      OUT_busy     <= 1'b0;
      OUT_resValid <= 1'b0;
      OUT_result   <= '0;
      OUT_tagDst   <= '0;
      OUT_nmDst    <= '0;
      OUT_sqN      <= '0;
    end else begin
      case (state)
        // Accept: latch the uop and operand magnitudes.
        IDLE: begin
          if (IN_valid && !killed(IN_sqN, IN_branchSqN, IN_branchTaken)) begin
            state     <= RUN;
            OUT_busy  <= 1'b1;
            tag_p0    <= IN_tagDst;
            nm_p0     <= IN_nmDst;
            sqn_p0    <= IN_sqN;
            is_rem_p0 <= IN_opcode[1];
            sgn_q_p0  <= is_signed & (IN_srcA[XLEN-1] ^ IN_srcB[XLEN-1]);
            sgn_r_p0  <= is_signed & IN_srcA[XLEN-1];
            bz_p0     <= in_bz;
            ovf_p0    <= in_ovf;
            srca_p0   <= IN_srcA;
            rem_p0    <= '0;
            quo_p0    <= neg_if(IN_srcA, is_signed & IN_srcA[XLEN-1]);
            dvs_p0    <= neg_if(IN_srcB, is_signed & IN_srcB[XLEN-1]);
`ifdef DIV_FASTPATH_EN
            cnt       <= (in_bz || in_ovf) ? CW'(XLEN-1) : '0;
`else
            cnt       <= '0;
`endif
          end
        end
        // One restoring step per cycle; the last step also registers the result.
        RUN: begin
          if (kill_held) begin
            state    <= IDLE;
            OUT_busy <= 1'b0;
          end else begin
            rem_p0 <= rem_nx;
            quo_p0 <= quo_nx;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(XLEN-1)) begin
              state        <= DONE;
              OUT_resValid <= 1'b1;
              OUT_result   <= res_fin;
              OUT_tagDst   <= tag_p0;
              OUT_nmDst    <= nm_p0;
              OUT_sqN      <= sqn_p0;
            end
          end
        end
        // Hold the result until the bus slot is granted or the uop is squashed.
        DONE: begin
          if (kill_held || !IN_wbStall) begin
            state        <= IDLE;
            OUT_busy     <= 1'b0;
            OUT_resValid <= 1'b0;
            OUT_result   <= '0;
            OUT_tagDst   <= '0;
            OUT_nmDst    <= '0;
            OUT_sqN      <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          OUT_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor checks each granted result.
module tb_div_unit;
  localparam int XLEN = 32;
`ifdef DIV_FASTPATH_EN
  localparam int FAST_LAT = 2;
`else
  localparam int FAST_LAT = 33;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            IN_valid;
  logic [XLEN-1:0] IN_srcA, IN_srcB;
  logic [1:0]      IN_opcode;
  logic [6:0]      IN_tagDst;
  logic [4:0]      IN_nmDst;
  logic [6:0]      IN_sqN;
  logic            IN_branchTaken;
  logic [6:0]      IN_branchSqN;
  logic            IN_wbStall;
  logic            OUT_busy, OUT_resValid;
  logic [XLEN-1:0] OUT_result;
  logic [6:0]      OUT_tagDst;
  logic [4:0]      OUT_nmDst;
  logic [6:0]      OUT_sqN;

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .IN_valid(IN_valid), .IN_srcA(IN_srcA), .IN_srcB(IN_srcB),
    .IN_opcode(IN_opcode), .IN_tagDst(IN_tagDst), .IN_nmDst(IN_nmDst), .IN_sqN(IN_sqN),
    .IN_branchTaken(IN_branchTaken), .IN_branchSqN(IN_branchSqN), .IN_wbStall(IN_wbStall),
    .OUT_busy(OUT_busy), .OUT_resValid(OUT_resValid), .OUT_result(OUT_result),
    .OUT_tagDst(OUT_tagDst), .OUT_nmDst(OUT_nmDst), .OUT_sqN(OUT_sqN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [6:0]  tag;
    logic [4:0]  nm;
    logic [6:0]  sqn;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every granted result must match the oldest expectation, at the expected cycle.
  always @(negedge clk) begin
    if (!rst && OUT_resValid && !IN_wbStall) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got result %h tag %h, expected no result (cycle %0d)",
                 OUT_result, OUT_tagDst, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", OUT_result, mon_e.res);
        check("tag", 32'(OUT_tagDst), 32'(mon_e.tag));
        check("nm_sqn", {20'd0, OUT_nmDst, OUT_sqN}, {20'd0, mon_e.nm, mon_e.sqn});
        check("grant_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Present one uop for one cycle; lat is the cycle offset at which it should be granted.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] tag, input logic [6:0] sqn, input logic [31:0] expv,
                       input int lat, input bit expect_res, output int t0);
    exp_t e;
    t0 = cyc;
    IN_valid  = 1'b1;
    IN_opcode = op;
    IN_srcA   = a;
    IN_srcB   = b;
    IN_tagDst = tag;
    IN_nmDst  = tag[4:0];
    IN_sqN    = sqn;
    if (expect_res) begin
      e.res = expv; e.tag = tag; e.nm = tag[4:0]; e.sqn = sqn; e.cyc = t0 + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    IN_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (OUT_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", OUT_busy, n);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [6:0] tag, input logic [31:0] expv, input bit special);
    int t0;
    issue(op, a, b, tag, tag, expv, special ? FAST_LAT : 33, 1'b1, t0);
    wait_idle();
  endtask

  task automatic flush_case(input logic [6:0] sqn, input logic [6:0] bsqn, input bit survives);
    int t0;
    issue(2'd0, 32'd100, 32'd7, 7'h21, sqn, 32'd14, 33, survives, t0);
    repeat (5) @(posedge clk);
    #1;
    IN_branchTaken = 1'b1;
    IN_branchSqN   = bsqn;
    @(posedge clk); #1;
    IN_branchTaken = 1'b0;
    check("flush_busy", 32'(OUT_busy), 32'(survives));
    check("flush_resvalid", 32'(OUT_resValid), 32'd0);
    if (survives) wait_idle();
    else repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; IN_valid = 1'b0; IN_srcA = '0; IN_srcB = '0; IN_opcode = '0;
    IN_tagDst = '0; IN_nmDst = '0; IN_sqN = '0; IN_branchTaken = 1'b0;
    IN_branchSqN = '0; IN_wbStall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 32'(OUT_busy), 32'd0);
    check("reset_resvalid", 32'(OUT_resValid), 32'd0);
    check("reset_result", OUT_result, 32'd0);
    check("reset_fields", {13'd0, OUT_tagDst, OUT_nmDst, OUT_sqN}, 32'd0);

    // Basic timing: DIV 100/7 with tag 0x12.
    issue(2'd0, 32'd100, 32'd7, 7'h12, 7'd1, 32'd14, 33, 1'b1, t0);
    check("busy_T1", 32'(OUT_busy), 32'd1);
    repeat (31) @(posedge clk);
    #1;
    check("resvalid_T32", 32'(OUT_resValid), 32'd0);
    @(posedge clk); #1;
    check("busy_T33", 32'(OUT_busy), 32'd1);
    check("resvalid_T33", 32'(OUT_resValid), 32'd1);
    @(posedge clk); #1;
    check("busy_T34", 32'(OUT_busy), 32'd0);
    check("resvalid_T34", 32'(OUT_resValid), 32'd0);

    // Directed vectors.
    run(2'd2, 32'hFFFF_FFF9, 32'd2, 7'h13, 32'hFFFF_FFFF, 1'b0);
    run(2'd3, 32'hFFFF_FFF9, 32'd2, 7'h14, 32'd1, 1'b0);
    run(2'd1, 32'hFFFF_FFFF, 32'd1, 7'h15, 32'hFFFF_FFFF, 1'b0);
    run(2'd0, 32'hFFFF_FF9C, 32'd7, 7'h16, 32'hFFFF_FFF2, 1'b0);
    run(2'd2, 32'hFFFF_FF9C, 32'd7, 7'h17, 32'hFFFF_FFFE, 1'b0);
    run(2'd0, 32'd123, 32'd0, 7'h18, 32'hFFFF_FFFF, 1'b1);
    run(2'd2, 32'd5, 32'd0, 7'h19, 32'd5, 1'b1);
    run(2'd2, 32'hFFFF_FFFB, 32'd0, 7'h1A, 32'hFFFF_FFFB, 1'b1);
    run(2'd1, 32'd7, 32'd0, 7'h1B, 32'hFFFF_FFFF, 1'b1);
    run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 7'h1C, 32'h8000_0000, 1'b1);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 7'h1D, 32'd0, 1'b1);

    // Flush: younger squashed, equal survives, wrap-around younger squashed.
    flush_case(7'd10, 7'd9, 1'b0);
    flush_case(7'd10, 7'd10, 1'b1);
    flush_case(7'd2, 7'd120, 1'b0);

    // Result-bus stall for three cycles, granted on the fourth.
    issue(2'd1, 32'd1000, 32'd3, 7'h30, 7'd40, 32'd333, 36, 1'b1, t0);
    IN_wbStall = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("stall_resvalid", 32'(OUT_resValid), 32'd1);
      check("stall_result", OUT_result, 32'd333);
      check("stall_tag", 32'(OUT_tagDst), 32'h30);
      @(posedge clk); #1;
    end
    IN_wbStall = 1'b0;
    check("grant_busy", 32'(OUT_busy), 32'd1);
    @(posedge clk); #1;
    check("post_grant_busy", 32'(OUT_busy), 32'd0);

    // Reset in the middle of an operation, then a fresh accept.
    issue(2'd0, 32'd50, 32'd5, 7'h40, 7'd50, 32'd10, 33, 1'b0, t0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(OUT_busy), 32'd0);
    check("rst_resvalid", 32'(OUT_resValid), 32'd0);
    rst = 1'b0;
    issue(2'd1, 32'd1000, 32'd10, 7'h41, 7'd51, 32'd100, 33, 1'b1, t0);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
